alu_seq: RTL and testbench

Parametrised, registered integer ALU with a valid/ready handshake on both sides, condition flags, and a multi-cycle shift-add multiplier. It replaces the purely combinational 4-bit lab ALU as the execution unit feeding result/LED display logic. Single-cycle ops and the multi-cycle multiply share one output register.

---
 rtl/alu_seq.sv | 164 ++++++++++++++++
 tb/tb_alu_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered integer ALU with valid/ready handshakes, condition flags and a
// shift-add multiplier; single-cycle ops and MUL share one output register.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_NOT  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_EQ   = 4'd7;
  localparam logic [3:0] OP_SLTU = 4'd8;
  localparam logic [3:0] OP_SHL  = 4'd9;
  localparam logic [3:0] OP_SHR  = 4'd10;
  localparam logic [3:0] OP_SRA  = 4'd11;
  localparam logic [3:0] OP_MUL  = 4'd12;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state_q, state_d;

  logic               accept, is_mul, mul_last;
  logic [WIDTH:0]     sum, diff;
  logic [SHW-1:0]     shamt;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v, alu_err;
  logic [2*WIDTH-1:0] mcand, acc, acc_nxt;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (op == OP_MUL);
  assign sum       = {1'b0, a} + {1'b0, b};
  // Top bit of the widened difference is the unsigned borrow (a < b).
  assign diff      = {1'b0, a} - {1'b0, b};
  assign shamt     = b[SHW-1:0];
  assign acc_nxt   = acc + (mplier[0] ? mcand : '0);
  assign mul_last  = (cnt == CW'(WIDTH - 1));

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_NOT:  alu_res = ~a;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, (a == b)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SHL:  alu_res = a << shamt;
      OP_SHR:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $signed(a) >>> shamt;
      OP_MUL:  alu_res = '0;
      default: alu_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = is_mul ? BUSY : DONE;
      end
      BUSY: begin
        if (mul_last) state_d = DONE;
      end
      DONE: begin
        // A consumed result frees the slot in the same cycle.
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) state_d = is_mul ? BUSY : DONE;
          else          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
      err    <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (accept) begin
      if (is_mul) begin
        mcand  <= {{WIDTH{1'b0}}, a};
        mplier <= b;
        acc    <= '0;
        cnt    <= '0;
      end else begin
        result <= alu_res;
        flag_z <= (alu_res == '0);
        flag_n <= alu_res[WIDTH-1];
        flag_c <= alu_c;
        flag_v <= alu_v;
        err    <= alu_err;
      end
    end else if (state_q == BUSY) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (mul_last) begin
        result <= acc_nxt[WIDTH-1:0];
        flag_z <= (acc_nxt[WIDTH-1:0] == '0);
        flag_n <= acc_nxt[WIDTH-1];
        flag_c <= |acc_nxt[2*WIDTH-1:WIDTH];
        flag_v <= 1'b0;
        err    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=4: directed cases plus random ops
// under random backpressure, checked against an integer reference model.
module tb_alu_seq;
  localparam int W    = 4;
  localparam int SHW  = $clog2(W);
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   op = '0;
  logic [W-1:0] a = '0, b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         flag_z, flag_n, flag_c, flag_v, err;

  int checks = 0;
  int errors = 0;
  bit rand_bp = 1'b0;
  logic [W+4:0] q[$];

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed views as ordinary ints.
  function automatic logic [W+4:0] model(input int o, input int x, input int y);
    int half, sx, sy, s, r, sh, p;
    bit c, v, e;
    logic [31:0] rv;
    half = 1 << (W - 1);
    sx = (x >= half) ? x - (1 << W) : x;
    sy = (y >= half) ? y - (1 << W) : y;
    sh = y % (1 << SHW);
    r = 0; c = 0; v = 0; e = 0;
    case (o)
      0: begin r = x + y; c = (r > MASK); s = sx + sy; v = (s > half - 1) || (s < -half); end
      1: begin r = x - y; c = (x < y);    s = sx - sy; v = (s > half - 1) || (s < -half); end
      2: r = ~x;
      3: r = x & y;
      4: r = x | y;
      5: r = x ^ y;
      6: r = (sx < sy) ? 1 : 0;
      7: r = (x == y) ? 1 : 0;
      8: r = (x < y) ? 1 : 0;
      9: r = (sh >= W) ? 0 : (x << sh);
      10: r = x >> sh;
      11: r = sx >>> sh;
      12: begin p = x * y; r = p; c = ((p >> W) != 0); end
      default: begin r = 0; e = 1; end
    endcase
    rv = r & MASK;
    return {rv[W-1:0], (rv == 0), rv[W-1], c, v, e};
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic issue(input int o, input int x, input int y, output int waits);
    in_valid = 1'b1;
    op = 4'(o); a = W'(x); b = W'(y);
    waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
    end else begin
      q.push_back(model(o, x, y));
      @(posedge clk); #1;
      in_valid = 1'b0;
      op = 4'($urandom); a = W'($urandom); b = W'($urandom);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_output", 32'(out_valid), 32'd0);
      else chk("scoreboard", {result, flag_z, flag_n, flag_c, flag_v, err}, q.pop_front());
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_bp) out_ready = ($urandom % 4) != 0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_result_flags", {result, flag_z, flag_n, flag_c, flag_v, err}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_reset", 32'(in_ready), 32'd1);
    out_ready = 1'b1;

    // ADD overflow, latency 1
    issue(0, 4'b0111, 4'b0001, w);
    chk("add_latency", 32'(out_valid), 32'd1);
    chk("add_result", {result, flag_z, flag_n, flag_c, flag_v}, {4'b1000, 4'b0101});
    issue(1, 4'b0000, 4'b0001, w);
    chk("sub_result", {result, flag_n, flag_c, flag_v}, {4'b1111, 3'b110});
    issue(6, 4'b1110, 4'b0001, w);
    chk("slt_result", 32'(result), 32'd1);
    issue(8, 4'b1110, 4'b0001, w);
    chk("sltu_result", 32'(result), 32'd0);

    // MUL: exactly W busy cycles with in_ready low
    issue(12, 4'b0011, 4'b0101, w);
    for (int k = 0; k < W; k++) begin
      chk("mul_busy_valid", 32'(out_valid), 32'd0);
      chk("mul_busy_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    chk("mul_done", {out_valid, result, flag_c}, {1'b1, 4'b1111, 1'b0});
    issue(12, 4'b0100, 4'b0100, w);
    repeat (W) @(posedge clk);
    #1;
    chk("mul_ovf", {out_valid, result, flag_z, flag_c}, {1'b1, 4'b0000, 2'b11});

    // Backpressure: output held, new request ignored, then same-cycle accept
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(0, 4'b0111, 4'b0001, w);
    in_valid = 1'b1; op = 4'd5; a = 4'b1010; b = 4'b0110;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("stall_hold", {out_valid, in_ready, result, flag_z, flag_n, flag_c, flag_v, err},
          {2'b10, 4'b1000, 5'b01010});
    end
    out_ready = 1'b1;
    issue(5, 4'b1010, 4'b0110, w);
    chk("b2b_no_bubble", 32'(w), 32'd0);
    chk("b2b_xor", {out_valid, result}, {1'b1, 4'b1100});

    // Reset during the second BUSY cycle of a MUL
    issue(12, 4'b0011, 4'b0101, w);
    @(posedge clk); #1;
    rst = 1'b1;
    q.delete();
    #1;
    chk("rst_mid_mul", {out_valid, result, flag_z, flag_n, flag_c, flag_v, err}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    issue(0, 4'b0010, 4'b0011, w);
    chk("add_after_rst", {out_valid, result, err}, {1'b1, 4'b0101, 1'b0});

    // Illegal op, then a legal one clears err
    issue(14, 4'b1011, 4'b0110, w);
    chk("illegal", {result, flag_z, flag_c, err}, {4'b0000, 3'b101});
    issue(3, 4'b1100, 4'b1010, w);
    chk("and_clears_err", {result, err}, {4'b1000, 1'b0});

    // Random ops under random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++)
      issue($urandom % 16, $urandom & MASK, $urandom & MASK, w);
    rand_bp = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int k = 0; k < 100 && q.size() != 0; k++) @(posedge clk);
    #1;
    chk("drain", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
